// File: rtl/stepgen_pkg.sv
// Shared types and constants for the segment-driven step/dir pulse generator.
package stepgen_pkg;

  // Sequencer states; the segment-end decision is combinational and has no state of its own.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DHOLD = 3'd2,
    ST_HIGH  = 3'd3,
    ST_LOW   = 3'd4
  } state_e;

  // Host write addresses.
  localparam logic [1:0] WA_PERIOD = 2'd0;
  localparam logic [1:0] WA_DELTA  = 2'd1;
  localparam logic [1:0] WA_PUSH   = 2'd2;
  localparam logic [1:0] WA_CTRL   = 2'd3;

  // Host read addresses.
  localparam logic [1:0] RA_LEVEL  = 2'd0;
  localparam logic [1:0] RA_COUNT  = 2'd1;
  localparam logic [1:0] RA_PERIOD = 2'd2;
  localparam logic [1:0] RA_STATUS = 2'd3;

  // Control register bit positions.
  localparam int unsigned CTRL_ABORT = 0;
  localparam int unsigned CTRL_CLR   = 1;

  // Width of one queued segment record {dir, count, period_low, delta}.
  function automatic int unsigned seg_width(input int unsigned cnt_w, input int unsigned per_w);
    return 1 + cnt_w + 2 * per_w;
  endfunction

endpackage

// File: rtl/seg_fifo.sv
// Synchronous FIFO for motion segments with simultaneous push/pop and flush.
module seg_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             push_ok, pop_ok;

  assign full  = (level_q == (AW+1)'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign dout  = mem_q[rd_ptr_q];

  // A push into a full FIFO is only taken when a pop frees the head slot in the same clk.
  assign pop_ok  = pop & ~empty & ~flush;
  assign push_ok = push & (~full | pop_ok) & ~flush;

  // Pointer and level update.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level_d = level_q + (AW+1)'(1);
        2'b01:   level_d = level_q - (AW+1)'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Pointer and level registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents are don't-care while the slot is empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/stepgen_seg.sv
// Single-axis step/dir generator executing queued motion segments back-to-back,
// with dir-hold timing and a clamped linear period ramp.
module stepgen_seg
  import stepgen_pkg::*;
#(
  parameter int unsigned CNT_W  = 10,
  parameter int unsigned PER_W  = 16,
  parameter int unsigned HIGH_W = 5,
  parameter int unsigned HOLD_W = 5,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned LOW_WM = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              wr_en,
  input  logic [1:0]        wr_addr,
  input  logic [15:0]       wr_data,
  input  logic [1:0]        rd_addr,
  output logic [15:0]       rd_data,
  input  logic [HIGH_W-1:0] pulse_high,
  input  logic [HOLD_W-1:0] dir_hold,
  input  logic              hold_in,
  output logic              step,
  output logic              dir,
  output logic              dir_change,
  output logic              busy,
  output logic              buf_low,
  output logic              fifo_full
);

  localparam int unsigned SEG_W = seg_width(CNT_W, PER_W);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  state_e             state_q, state_d;
  logic               tick_q;
  logic [PER_W-1:0]   per_stg_q, per_stg_d;
  logic [PER_W-1:0]   dlt_stg_q, dlt_stg_d;
  logic [SEG_W-1:0]   seg_q, seg_d;
  logic               dir_q, dir_d;
  logic               dir_change_q, dir_change_d;
  logic               step_q, step_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PER_W-1:0]   cur_per_q, cur_per_d;
  logic [PER_W-1:0]   dlt_q, dlt_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [HIGH_W-1:0]  high_cnt_q, high_cnt_d;
  logic [PER_W-1:0]   low_cnt_q, low_cnt_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;

  logic               tick_go;
  logic               wr_push, wr_ctrl, abort, clr_flags;
  logic               fifo_pop, fifo_empty;
  logic [SEG_W-1:0]   fifo_dout;
  logic [LVL_W-1:0]   fifo_level;
  logic               seg_dir;
  logic [CNT_W-1:0]   seg_cnt;
  logic [PER_W-1:0]   seg_per, seg_dlt;
  logic [HIGH_W-1:0]  high_init;
  logic [PER_W+1:0]   per_sum;
  logic [PER_W-1:0]   per_next;
  logic               go_high, seg_end;

  assign tick_go   = tick & ~tick_q & ~hold_in;
  assign wr_push   = wr_en & (wr_addr == WA_PUSH);
  assign wr_ctrl   = wr_en & (wr_addr == WA_CTRL);
  assign abort     = wr_ctrl & wr_data[CTRL_ABORT];
  assign clr_flags = wr_ctrl & wr_data[CTRL_CLR];

  assign seg_dir   = seg_q[SEG_W-1];
  assign seg_cnt   = seg_q[SEG_W-2 -: CNT_W];
  assign seg_per   = seg_q[2*PER_W-1 -: PER_W];
  assign seg_dlt   = seg_q[PER_W-1:0];

  assign high_init = (pulse_high == '0) ? HIGH_W'(1) : pulse_high;

  seg_fifo #(
    .WIDTH(SEG_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr_push),
    .pop   (fifo_pop),
    .flush (abort),
    .din   ({wr_data[15], wr_data[CNT_W-1:0], per_stg_q, dlt_stg_q}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Two guard bits: the top one flags a negative sum, the next one overflow past 2^PER_W-1.
  assign per_sum = {2'b00, cur_per_q} + {{2{dlt_q[PER_W-1]}}, dlt_q};

  // Clamp the ramped period into 1 .. 2^PER_W-1.
  always_comb begin
    if (per_sum[PER_W+1] || (per_sum == '0)) per_next = PER_W'(1);
    else if (per_sum[PER_W])                 per_next = '1;
    else                                     per_next = per_sum[PER_W-1:0];
  end

  // Staging registers, segment sequencer and sticky flags.
  always_comb begin
    state_d      = state_q;
    per_stg_d    = per_stg_q;
    dlt_stg_d    = dlt_stg_q;
    dir_d        = dir_q;
    dir_change_d = 1'b0;
    cnt_d        = cnt_q;
    cur_per_d    = cur_per_q;
    dlt_d        = dlt_q;
    hold_cnt_d   = hold_cnt_q;
    high_cnt_d   = high_cnt_q;
    low_cnt_d    = low_cnt_q;
    ovf_d        = ovf_q;
    unf_d        = unf_q;
    fifo_pop     = 1'b0;
    go_high      = 1'b0;
    seg_end      = 1'b0;

    if (wr_en && (wr_addr == WA_PERIOD)) per_stg_d = wr_data[PER_W-1:0];
    if (wr_en && (wr_addr == WA_DELTA))  dlt_stg_d = wr_data[PER_W-1:0];

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && !hold_in) begin
          fifo_pop = 1'b1;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cnt_d     = seg_cnt;
        cur_per_d = (seg_per == '0) ? PER_W'(1) : seg_per;
        dlt_d     = seg_dlt;
        if (seg_dir != dir_q) begin
          dir_d        = seg_dir;
          dir_change_d = 1'b1;
          hold_cnt_d   = dir_hold;
          state_d      = ST_DHOLD;
        end else if (seg_cnt == '0) begin
          seg_end = 1'b1;
        end else begin
          go_high = 1'b1;
        end
      end
      ST_DHOLD: begin
        if ((hold_cnt_q == '0) || (tick_go && (hold_cnt_q == HOLD_W'(1)))) begin
          hold_cnt_d = '0;
          if (cnt_q == '0) seg_end = 1'b1;
          else             go_high = 1'b1;
        end else if (tick_go) begin
          hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        end
      end
      ST_HIGH: begin
        if (tick_go) begin
          if (high_cnt_q == HIGH_W'(1)) begin
            low_cnt_d = cur_per_q;
            state_d   = ST_LOW;
          end else begin
            high_cnt_d = high_cnt_q - HIGH_W'(1);
          end
        end
      end
      ST_LOW: begin
        if (tick_go) begin
          if (low_cnt_q == PER_W'(1)) begin
            cnt_d     = cnt_q - CNT_W'(1);
            cur_per_d = per_next;
            if (cnt_q == CNT_W'(1)) seg_end = 1'b1;
            else                    go_high = 1'b1;
          end else begin
            low_cnt_d = low_cnt_q - PER_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (go_high) begin
      high_cnt_d = high_init;
      state_d    = ST_HIGH;
    end

    // Segment end chains straight into the next LOAD so no tick is lost between segments.
    if (seg_end) begin
      if (!fifo_empty && !hold_in) begin
        fifo_pop = 1'b1;
        state_d  = ST_LOAD;
      end else begin
        state_d = ST_IDLE;
        if (fifo_empty) unf_d = 1'b1;
      end
    end

    if (wr_push && fifo_full && !fifo_pop) ovf_d = 1'b1;

    if (abort) begin
      state_d      = ST_IDLE;
      fifo_pop     = 1'b0;
      dir_d        = dir_q;
      dir_change_d = 1'b0;
    end

    if (clr_flags) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
  end

  assign seg_d  = fifo_pop ? fifo_dout : seg_q;
  assign step_d = (state_d == ST_HIGH);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      tick_q       <= 1'b0;
      per_stg_q    <= '0;
      dlt_stg_q    <= '0;
      seg_q        <= '0;
      dir_q        <= 1'b0;
      dir_change_q <= 1'b0;
      step_q       <= 1'b0;
      cnt_q        <= '0;
      cur_per_q    <= '0;
      dlt_q        <= '0;
      hold_cnt_q   <= '0;
      high_cnt_q   <= '0;
      low_cnt_q    <= '0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick;
      per_stg_q    <= per_stg_d;
      dlt_stg_q    <= dlt_stg_d;
      seg_q        <= seg_d;
      dir_q        <= dir_d;
      dir_change_q <= dir_change_d;
      step_q       <= step_d;
      cnt_q        <= cnt_d;
      cur_per_q    <= cur_per_d;
      dlt_q        <= dlt_d;
      hold_cnt_q   <= hold_cnt_d;
      high_cnt_q   <= high_cnt_d;
      low_cnt_q    <= low_cnt_d;
      ovf_q        <= ovf_d;
      unf_q        <= unf_d;
    end
  end

  assign step       = step_q;
  assign dir        = dir_q;
  assign dir_change = dir_change_q;
  assign busy       = (state_q != ST_IDLE);
  assign buf_low    = (fifo_level <= LVL_W'(LOW_WM));

  // Host status read mux.
  always_comb begin
    case (rd_addr)
      RA_LEVEL:  rd_data = 16'(fifo_level);
      RA_COUNT:  rd_data = 16'(cnt_q);
      RA_PERIOD: rd_data = 16'(cur_per_q);
      default:   rd_data = {12'd0, ovf_q, unf_q, busy, dir_q};
    endcase
  end

endmodule

// File: tb/tb_stepgen_seg.sv
// Scoreboard bench for stepgen_seg: segment pushes queue expected pulse-train events,
// a negedge monitor measures high/low/dir-hold widths in ticks and checks them in order.
module tb_stepgen_seg;

  localparam int K_HIGH = 1;
  localparam int K_LOW  = 2;
  localparam int K_HOLD = 3;

  logic        clk, rst_n, tick, wr_en, hold_in;
  logic [1:0]  wr_addr, rd_addr;
  logic [15:0] wr_data, rd_data;
  logic [4:0]  pulse_high, dir_hold;
  logic        step, dir, dir_change, busy, buf_low, fifo_full;

  int          n_cmp = 0;
  int          n_err = 0;
  int          tick_n = 0;
  int          tick_half = 4;
  logic        mon_en = 1'b0;
  logic        mdir = 1'b0;
  logic [31:0] sb_q[$];
  logic [15:0] rv;

  stepgen_seg #(
    .CNT_W(10), .PER_W(16), .HIGH_W(5), .HOLD_W(5), .DEPTH(4), .LOW_WM(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data), .pulse_high(pulse_high),
    .dir_hold(dir_hold), .hold_in(hold_in), .step(step), .dir(dir),
    .dir_change(dir_change), .busy(busy), .buf_low(buf_low), .fifo_full(fifo_full)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Tick timebase; tick_n counts rises the DUT has consumed by the next negedge.
  initial begin
    int ph;
    ph = 0;
    tick = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      ph++;
      if (ph >= tick_half) begin
        ph = 0;
        tick = ~tick;
        if (tick) tick_n++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no-finish want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ev(input int k, input logic d, input int w);
    return {4'(k), 3'b000, d, 8'h00, 16'(w)};
  endfunction

  task automatic emit(input logic [31:0] obs);
    if (sb_q.size() == 0) check("sb_extra", obs, 32'h0);
    else                  check("step_ev", obs, sb_q.pop_front());
  endtask

  // Monitor: measures widths in consumed ticks and compares against the scoreboard.
  initial begin
    int t_rise, t_fall, t_dc, dc_len;
    logic step_p, busy_p, dc_p, low_pend, hold_pend;
    {t_rise, t_fall, t_dc, dc_len} = '0;
    {step_p, busy_p, dc_p, low_pend, hold_pend} = '0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        low_pend = 1'b0;
        hold_pend = 1'b0;
      end else begin
        if (step && !step_p) begin
          if (low_pend)  emit(ev(K_LOW, 1'b0, tick_n - t_fall));
          if (hold_pend) emit(ev(K_HOLD, 1'b0, tick_n - t_dc));
          low_pend = 1'b0;
          hold_pend = 1'b0;
          t_rise = tick_n;
        end
        if (!step && step_p) begin
          emit(ev(K_HIGH, dir, tick_n - t_rise));
          t_fall = tick_n;
          low_pend = 1'b1;
        end
        if (dir_change && !dc_p) begin
          if (low_pend) emit(ev(K_LOW, 1'b0, tick_n - t_fall));
          low_pend = 1'b0;
          t_dc = tick_n;
          hold_pend = 1'b1;
          dc_len = 0;
        end
        if (dir_change) dc_len++;
        if (!dir_change && dc_p) check("dc_width", dc_len, 1);
        if (!busy && busy_p && low_pend) begin
          emit(ev(K_LOW, 1'b0, tick_n - t_fall));
          low_pend = 1'b0;
        end
      end
      step_p = step;
      busy_p = busy;
      dc_p = dir_change;
    end
  end

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    @(posedge clk); #2;
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #2;
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [15:0] d);
    @(posedge clk); #2;
    rd_addr = a;
    @(negedge clk);
    d = rd_data;
  endtask

  // Reference pulse train for one segment, queued as it is pushed.
  task automatic model_seg(input logic sd, input int cnt, input int per, input logic [15:0] dlt);
    int cur, d, hi;
    d  = int'($signed(dlt));
    hi = (pulse_high == 0) ? 1 : int'(pulse_high);
    if (sd != mdir) begin
      sb_q.push_back(ev(K_HOLD, 1'b0, int'(dir_hold)));
      mdir = sd;
    end
    cur = (per == 0) ? 1 : per;
    for (int i = 0; i < cnt; i++) begin
      sb_q.push_back(ev(K_HIGH, sd, hi));
      sb_q.push_back(ev(K_LOW, 1'b0, cur));
      cur = cur + d;
      if (cur < 1) cur = 1;
      if (cur > 65535) cur = 65535;
    end
  endtask

  task automatic push_seg(input logic sd, input int cnt, input int per, input logic [15:0] dlt,
                          input logic expect_run);
    wr(2'd0, 16'(per));
    wr(2'd1, dlt);
    wr(2'd2, {sd, 5'd0, 10'(cnt)});
    if (expect_run) model_seg(sd, cnt, per, dlt);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((busy || sb_q.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drain"}, 32'(sb_q.size()), 32'd0);
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_step(input logic v, input int budget, input string tag);
    int n;
    n = 0;
    while (step !== v && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (step !== v) check({tag, "_timeout"}, {31'd0, step}, {31'd0, v});
  endtask

  task automatic wait_level(input logic [15:0] v, input string tag);
    int n;
    @(posedge clk); #2;
    rd_addr = 2'd0;
    n = 0;
    @(negedge clk);
    while (rd_data !== v && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (rd_data !== v) check({tag, "_timeout"}, 32'(rd_data), 32'(v));
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = 2'd3;
    hold_in = 1'b0; pulse_high = 5'd2; dir_hold = 5'd5;
    repeat (3) @(negedge clk);
    check("rst_step", {31'd0, step}, 32'd0);
    check("rst_dir", {31'd0, dir}, 32'd0);
    check("rst_dc", {31'd0, dir_change}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_status", 32'(rd_data), 32'd0);
    check("rst_buf_low", {31'd0, buf_low}, 32'd1);
    @(posedge clk); #2 rst_n = 1'b1;
    mon_en = 1'b1;

    // Basic train: 4 steps, high 2, low 3, then underrun.
    push_seg(1'b0, 4, 3, 16'h0000, 1'b1);
    wait_idle("basic");
    rd(2'd3, rv); check("basic_status", 32'(rv), 32'h4);
    wr(2'd3, 16'h0002);
    rd(2'd3, rv); check("clr_status", 32'(rv), 32'h0);

    // Direction change with 5-tick hold.
    push_seg(1'b1, 1, 3, 16'h0000, 1'b1);
    wait_idle("dirchg");
    rd(2'd3, rv); check("dirchg_status", 32'(rv), 32'h5);
    wr(2'd3, 16'h0002);

    // Down-ramp clamped at 1: lows 4, 2, 1, 1.
    push_seg(1'b1, 4, 4, 16'hFFFE, 1'b1);
    wait_idle("ramp");
    wr(2'd3, 16'h0002);

    // Seamless chain of two queued segments.
    hold_in = 1'b1;
    push_seg(1'b1, 3, 2, 16'h0000, 1'b1);
    push_seg(1'b1, 3, 2, 16'h0000, 1'b1);
    rd(2'd0, rv); check("chain_level", 32'(rv), 32'd2);
    @(posedge clk); #2 hold_in = 1'b0;
    wait_level(16'd0, "chain_pop");
    rd(2'd3, rv); check("chain_mid_status", 32'(rv), 32'h3);
    wait_idle("chain");
    rd(2'd3, rv); check("chain_status", 32'(rv), 32'h5);
    wr(2'd3, 16'h0002);

    // FIFO limits: 5 pushes into depth 4 under hold; pulse_high=0 acts as 1.
    pulse_high = 5'd0;
    hold_in = 1'b1;
    for (int i = 0; i < 5; i++) push_seg(1'b1, 1, 1, 16'h0000, (i < 4));
    @(negedge clk);
    check("full_flag", {31'd0, fifo_full}, 32'd1);
    check("full_buf_low", {31'd0, buf_low}, 32'd0);
    rd(2'd0, rv); check("full_level", 32'(rv), 32'd4);
    rd(2'd3, rv); check("ovf_status", 32'(rv), 32'h9);
    @(posedge clk); #2 hold_in = 1'b0;
    wait_level(16'd2, "lvl2");
    check("buf_low_at2", {31'd0, buf_low}, 32'd0);
    wait_level(16'd1, "lvl1");
    check("buf_low_at1", {31'd0, buf_low}, 32'd1);
    wait_idle("fifo");
    rd(2'd3, rv); check("fifo_status", 32'(rv), 32'hD);
    wr(2'd3, 16'h0002);
    rd(2'd3, rv); check("fifo_clr", 32'(rv), 32'h1);
    pulse_high = 5'd2;

    // Upper clamp: 0x8001 + 0x7FFF saturates to 0xFFFF (fast tick).
    mon_en = 1'b0;
    tick_half = 1;
    push_seg(1'b1, 2, 16'h8001, 16'h7FFF, 1'b0);
    wait_step(1'b1, 200, "clamp_r1");
    wait_step(1'b0, 200, "clamp_f1");
    wait_step(1'b1, 70000, "clamp_r2");
    rd(2'd2, rv); check("clamp_period", 32'(rv), 32'hFFFF);
    rd(2'd1, rv); check("clamp_count", 32'(rv), 32'd1);
    wr(2'd3, 16'h0003);
    tick_half = 4;

    // Abort mid-HIGH.
    pulse_high = 5'd8;
    push_seg(1'b1, 3, 5, 16'h0000, 1'b0);
    wait_step(1'b1, 200, "abort_rise");
    @(posedge clk); #2;
    wr_en = 1'b1; wr_addr = 2'd3; wr_data = 16'h0001;
    @(negedge clk);
    check("abort_pre_step", {31'd0, step}, 32'd1);
    @(posedge clk); #2 wr_en = 1'b0;
    @(negedge clk);
    check("abort_step", {31'd0, step}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_dir", {31'd0, dir}, 32'd1);
    rd(2'd0, rv); check("abort_level", 32'(rv), 32'd0);

    // Asynchronous reset mid-LOW.
    pulse_high = 5'd2;
    push_seg(1'b1, 3, 5, 16'h0000, 1'b0);
    wait_step(1'b1, 200, "rst_rise");
    wait_step(1'b0, 200, "rst_fall");
    check("low_busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_step", {31'd0, step}, 32'd0);
    check("arst_dir", {31'd0, dir}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    rd(2'd3, rv); check("arst_status", 32'(rv), 32'h0);
    rd(2'd0, rv); check("arst_level", 32'(rv), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stepgen_seg.md
Name: stepgen_seg

Overview:
- Parametrised, single-channel step/dir pulse generator; next generation of the per-axis pulse generator in the CPLD motion path.
- MCU pushes motion segments {dir, step count, low period, signed period delta} into a DEPTH-entry FIFO.
- Segments execute back-to-back with no gap, with internal dir-hold timing and a linear period ramp for acceleration.
- Instantiated once per axis; all axes share tick, hold_in and the period/hold configuration.

Parameters:
CNT_W, 10, step-count width per segment
PER_W, 16, low-period and delta width, in tick periods
HIGH_W, 5, step-high width config width
HOLD_W, 5, dir-hold width config width
DEPTH, 4, segment FIFO depth, power of 2, at least 2
LOW_WM, 1, buf_low asserted when FIFO level <= LOW_WM

Ports:
clk  in  1  global CPLD clock
rst_n  in  1  asynchronous active-low reset
tick  in  1  timebase; the rising edge is detected internally
wr_en  in  1  one-clk write strobe
wr_addr  in  2  0=period_low, 1=delta, 2={dir,count} and push, 3=control
wr_data  in  16  write data
rd_addr  in  2  status read select
rd_data  out  16  combinational read data
pulse_high  in  HIGH_W  step-high length in ticks (0 is treated as 1)
dir_hold  in  HOLD_W  ticks between a dir change and the next step
hold_in  in  1  global freeze: no segment pop, no tick counting
step  out  1  step pulse
dir  out  1  direction
dir_change  out  1  one-clk pulse when dir toggles
busy  out  1  segment executing
buf_low  out  1  FIFO level <= LOW_WM
fifo_full  out  1  FIFO full

Behaviour:
- Reset (async, rst_n=0):
  - step=0, dir=0, dir_change=0, busy=0.
  - FIFO empty, staging registers 0, sticky flags 0, state IDLE.
- tick edge: tick_rise = tick & ~tick_q, where tick_q is registered. One clk of latency from tick to counting.
- Writes:
  - addr0 and addr1 load the staging registers (low PER_W bits).
  - addr2 pushes {dir=wr_data[15], count=wr_data[CNT_W-1:0], period_low, delta}. Staging is retained.
  - Push while full: dropped, sticky ovf=1.
  - Push and pop in the same clk are both honoured, and the level is unchanged.
  - addr3 bit0 (abort): flush FIFO, state to IDLE, step=0 on the next clk, dir kept.
  - addr3 bit1: clear the sticky flags.
- Reads: rd_addr 0=level, 1=remaining count, 2=current period, 3={ovf, underrun, busy, dir} in bits 3:0.
- FSM states: IDLE, LOAD, DHOLD, HIGH, LOW.
  - IDLE: when the FIFO is non-empty and !hold_in, pop and go to LOAD.
  - LOAD (1 clk): latch the segment. cur_period=period_low, with 0 coerced to 1.
    - If the new dir != dir: dir<=new, dir_change=1 for one clk, hold_cnt=dir_hold, go to DHOLD.
    - Otherwise, count==0 goes to END and count!=0 goes to HIGH.
  - DHOLD: on tick_rise with !hold_in, decrement. At 0, or if dir_hold==0, go to HIGH (or END if count==0).
  - HIGH: step=1 and high_cnt=max(pulse_high,1). Each tick_rise decrements it; the tick taking it to 0 enters LOW with low_cnt=cur_period.
  - LOW: step=0. Each tick_rise decrements low_cnt; the tick taking it to 0 does the following:
    - count--.
    - cur_period = clamp(cur_period + signed delta, 1, 2^PER_W-1).
    - count==0 goes to END; otherwise go to HIGH.
  - END (combinational): pop and go to LOAD if the FIFO is non-empty and !hold_in. Otherwise go to IDLE and set sticky underrun if the FIFO is empty.
- hold_in freezes all counters and pops. step holds its current value; a HIGH in progress is stretched.
- busy = state != IDLE.
- Pulse-train arithmetic:
  - Step period is high + cur_period ticks.
  - Back-to-back segments add exactly one LOAD clk (sub-tick), so no tick is lost.

Decomposition:
- Package stepgen_pkg: state enum; write-address constants (WA_PERIOD=0, WA_DELTA=1, WA_PUSH=2, WA_CTRL=3); ctrl bit indices; segment record width function (1+CNT_W+2*PER_W).
- Sub-module seg_fifo: synchronous FIFO, parametrised WIDTH and DEPTH, with full/empty/level, simultaneous push/pop, and a flush input.

Test Plan:
- Basic train: period=3, delta=0, push count=4 dir=0, pulse_high=2. Expect 4 steps, each high 2 ticks and low 3 ticks, then busy=0 and underrun=1.
- Dir change: after a dir=0 segment, push dir=1 count=1 with dir_hold=5. Expect a one-clk dir_change, dir=1, then exactly 5 ticks before step rises.
- Ramp and clamp: period=4, delta=-2 (0xFFFE), count=4. Expect low periods of 4, 2, 1, 1 ticks. Also period=0xFFFE, delta=+5 saturates at 0xFFFF.
- Seamless chain: two count=3 segments queued. Expect 6 steps, an identical gap at the boundary, and underrun set only after the second segment.
- FIFO limits: 5 pushes with DEPTH=4 and hold_in=1. Expect fifo_full=1, ovf=1, level=4. Release hold_in: 4 segments execute and buf_low asserts at level<=1.
- Abort and reset: abort mid-HIGH gives step=0 on the next clk, level=0, busy=0. rst_n low mid-LOW clears all outputs asynchronously.
